// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage and IF/ID pipeline register.
// Owns the PC, issues one-word requests to instruction memory, buffers
// returned words in a 2-entry queue and hands one instruction per cycle to
// decode. Honours load-use stalls and EX-stage branch redirects.
//
// Optional build macro: FETCH_PERF_CNT_EN adds perf_stall_cycles and
// perf_redirects counters and their output ports.
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        stall,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic        if_id_valid,
   output logic [31:0] if_id_pc,
   output logic [31:0] if_id_instr,
   output logic [4:0]  if_id_rs1,
   output logic [4:0]  if_id_rs2
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0] perf_stall_cycles,
   output logic [31:0] perf_redirects
`endif
);

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   logic [31:0] pc_q, pc_d;
   logic        inflight_q, inflight_d;
   logic [31:0] inflight_pc_q, inflight_pc_d;

   logic [31:0] fifo_pc_q    [2];
   logic [31:0] fifo_pc_d    [2];
   logic [31:0] fifo_instr_q [2];
   logic [31:0] fifo_instr_d [2];
   logic        rd_ptr_q, rd_ptr_d;
   logic [1:0]  count_q, count_d;

   logic        if_id_valid_q, if_id_valid_d;
   logic [31:0] if_id_pc_q, if_id_pc_d;
   logic [31:0] if_id_instr_q, if_id_instr_d;

   logic        grant;
   logic        resp;
   logic        push;
   logic        pop;
   logic        wr_ptr;

   // Only request when the queue plus the outstanding response still fit,
   // so the response path never needs backpressure.
   always_comb begin
      imem_req  = !reset && !redirect_valid &&
                  ((count_q + {1'b0, inflight_q}) < 2'd2);
      imem_addr = pc_q;
      grant     = imem_req && imem_gnt;
      resp      = inflight_q && imem_rvalid;
      wr_ptr    = rd_ptr_q ^ count_q[0];
   end

   // Next-state for PC, in-flight tag, queue and IF/ID register.
   always_comb begin
      pc_d          = pc_q;
      inflight_d    = 1'b0;
      inflight_pc_d = inflight_pc_q;
      fifo_pc_d     = fifo_pc_q;
      fifo_instr_d  = fifo_instr_q;
      rd_ptr_d      = rd_ptr_q;
      count_d       = count_q;
      if_id_valid_d = if_id_valid_q;
      if_id_pc_d    = if_id_pc_q;
      if_id_instr_d = if_id_instr_q;
      push          = 1'b0;
      pop           = 1'b0;

      if (redirect_valid) begin
         // Wrong-path work is discarded, including a response landing now.
         pc_d          = redirect_pc;
         rd_ptr_d      = 1'b0;
         count_d       = 2'd0;
         if_id_valid_d = 1'b0;
         if_id_instr_d = NOP_INSTR;
      end else begin
         if (grant) begin
            pc_d          = pc_q + 32'd4;
            inflight_d    = 1'b1;
            inflight_pc_d = pc_q;
         end

         if (!stall) begin
            if (count_q != 2'd0) begin
               if_id_valid_d = 1'b1;
               if_id_pc_d    = fifo_pc_q[rd_ptr_q];
               if_id_instr_d = fifo_instr_q[rd_ptr_q];
               pop           = 1'b1;
               push          = resp;
            end else if (resp) begin
               // Empty queue: the response goes straight to decode.
               if_id_valid_d = 1'b1;
               if_id_pc_d    = inflight_pc_q;
               if_id_instr_d = imem_rdata;
            end else begin
               if_id_valid_d = 1'b0;
            end
         end else begin
            push = resp;
         end

         // The write slot is never the head being popped: a push with
         // count 2 is ruled out by the request rule.
         if (push) begin
            fifo_pc_d[wr_ptr]    = inflight_pc_q;
            fifo_instr_d[wr_ptr] = imem_rdata;
         end
         if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
         end
         count_d = count_q + {1'b0, push} - {1'b0, pop};
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         pc_q            <= RESET_PC;
         inflight_q      <= 1'b0;
         inflight_pc_q   <= 32'd0;
         fifo_pc_q[0]    <= 32'd0;
         fifo_pc_q[1]    <= 32'd0;
         fifo_instr_q[0] <= NOP_INSTR;
         fifo_instr_q[1] <= NOP_INSTR;
         rd_ptr_q        <= 1'b0;
         count_q         <= 2'd0;
         if_id_valid_q   <= 1'b0;
         if_id_pc_q      <= 32'd0;
         if_id_instr_q   <= NOP_INSTR;
      end else begin
         pc_q          <= pc_d;
         inflight_q    <= inflight_d;
         inflight_pc_q <= inflight_pc_d;
         fifo_pc_q     <= fifo_pc_d;
         fifo_instr_q  <= fifo_instr_d;
         rd_ptr_q      <= rd_ptr_d;
         count_q       <= count_d;
         if_id_valid_q <= if_id_valid_d;
         if_id_pc_q    <= if_id_pc_d;
         if_id_instr_q <= if_id_instr_d;
      end
   end

   // IF/ID outputs; register fields read as zero for a bubble so the hazard
   // detector never matches on stale data.
   always_comb begin
      if_id_valid = if_id_valid_q;
      if_id_pc    = if_id_pc_q;
      if_id_instr = if_id_instr_q;
      if_id_rs1   = if_id_valid_q ? if_id_instr_q[19:15] : 5'd0;
      if_id_rs2   = if_id_valid_q ? if_id_instr_q[24:20] : 5'd0;
   end

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] perf_stall_q, perf_stall_d;
   logic [31:0] perf_redir_q, perf_redir_d;

   // Stall cycles count only when no redirect overrides the stall.
   always_comb begin
      perf_stall_d = perf_stall_q;
      perf_redir_d = perf_redir_q;
      if (redirect_valid) begin
         perf_redir_d = perf_redir_q + 32'd1;
      end else if (stall) begin
         perf_stall_d = perf_stall_q + 32'd1;
      end
   end

   // Counter registers, wrapping naturally at 2^32.
   always_ff @(posedge clock) begin
      if (reset) begin
         perf_stall_q <= 32'd0;
         perf_redir_q <= 32'd0;
      end else begin
         perf_stall_q <= perf_stall_d;
         perf_redir_q <= perf_redir_d;
      end
   end

   assign perf_stall_cycles = perf_stall_q;
   assign perf_redirects    = perf_redir_q;
`endif

endmodule
